// File: rtl/copperv_pkg.sv
// Shared CopperV bus definitions: read-arbiter FSM states, grant encoding
// and the request selection helper used by the bus arbiter.
package copperv_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // Picks the read winner. A lone requester always wins. On contention the
  // round-robin mode hands the bus to the port not granted last, otherwise
  // the data port has fixed priority.
  function automatic grant_e pick_grant(input logic   i_req,
                                        input logic   d_req,
                                        input logic   rr_en,
                                        input grant_e last);
    grant_e g;
    g = GRANT_D;
    if (i_req && !d_req) begin
      g = GRANT_I;
    end else if (i_req && d_req && rr_en) begin
      g = (last == GRANT_D) ? GRANT_I : GRANT_D;
    end
    return g;
  endfunction

endpackage

// File: rtl/copperv_bus_arbiter.sv
// Arbitrates the instruction and data read ports onto one memory read port
// (one read outstanding at a time); data writes pass straight through.
// Optional feature: define ARBITER_RR_EN for round-robin read arbitration,
// otherwise contention always goes to the data port.
module copperv_bus_arbiter
  import copperv_pkg::*;
#(
  parameter int bus_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  // instruction read
  input  logic                 i_raddr_valid,
  output logic                 i_raddr_ready,
  input  logic [bus_width-1:0] i_raddr,
  output logic                 i_rdata_valid,
  input  logic                 i_rdata_ready,
  output logic [bus_width-1:0] i_rdata,
  // instruction write (not supported)
  input  logic                 i_waddr_valid,
  output logic                 i_waddr_ready,
  input  logic [bus_width-1:0] i_waddr,
  input  logic                 i_wdata_valid,
  output logic                 i_wdata_ready,
  input  logic [bus_width-1:0] i_wdata,
  // data read
  input  logic                 d_raddr_valid,
  output logic                 d_raddr_ready,
  input  logic [bus_width-1:0] d_raddr,
  output logic                 d_rdata_valid,
  input  logic                 d_rdata_ready,
  output logic [bus_width-1:0] d_rdata,
  // data write
  input  logic                 d_waddr_valid,
  output logic                 d_waddr_ready,
  input  logic [bus_width-1:0] d_waddr,
  input  logic                 d_wdata_valid,
  output logic                 d_wdata_ready,
  input  logic [bus_width-1:0] d_wdata,
  // memory read
  output logic                 m_raddr_valid,
  input  logic                 m_raddr_ready,
  output logic [bus_width-1:0] m_raddr,
  input  logic                 m_rdata_valid,
  output logic                 m_rdata_ready,
  input  logic [bus_width-1:0] m_rdata,
  // memory write
  output logic                 m_waddr_valid,
  input  logic                 m_waddr_ready,
  output logic [bus_width-1:0] m_waddr,
  output logic                 m_wdata_valid,
  input  logic                 m_wdata_ready,
  output logic [bus_width-1:0] m_wdata,
  // arbitration status
  output logic                 grant_d
);

  rd_state_e state_q, state_d;
  grant_e    gnt_q, gnt_d;
  grant_e    last_gnt;
  logic      rr_en;
  logic      in_addr, in_data;
  logic      sel_d;
  logic      sel_rdata_ready;

  // Instruction-side write channels are never used by the core.
  logic unused_iw;
  assign unused_iw = ^{i_waddr_valid, i_wdata_valid, i_waddr, i_wdata};

`ifdef ARBITER_RR_EN
  grant_e rr_last_q;

  // Round-robin pointer: remembers which port won the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= GRANT_I;
    end else if (state_q == R_IDLE && (i_raddr_valid || d_raddr_valid)) begin
      rr_last_q <= gnt_d;
    end
  end

  assign rr_en    = 1'b1;
  assign last_gnt = rr_last_q;
`else
  assign rr_en    = 1'b0;
  assign last_gnt = GRANT_I;
`endif

  // State and grant registers; reset abandons any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= R_IDLE;
      gnt_q   <= GRANT_I;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  assign sel_d           = (gnt_q == GRANT_D);
  assign sel_rdata_ready = sel_d ? d_rdata_ready : i_rdata_ready;

  // Next-state logic; the grant is only ever updated from R_IDLE.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      R_IDLE: begin
        if (i_raddr_valid || d_raddr_valid) begin
          gnt_d   = pick_grant(i_raddr_valid, d_raddr_valid, rr_en, last_gnt);
          state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (m_raddr_ready) state_d = R_DATA;
      end
      R_DATA: begin
        if (m_rdata_valid && sel_rdata_ready) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Read-side handshakes are forced low while reset is held, even if the
  // state register still shows an in-flight read.
  assign in_addr = (state_q == R_ADDR) && !rst;
  assign in_data = (state_q == R_DATA) && !rst;

  // Read path steering toward memory and back to the granted port.
  always_comb begin
    m_raddr_valid = in_addr;
    m_raddr       = sel_d ? d_raddr : i_raddr;
    i_raddr_ready = in_addr && !sel_d && m_raddr_ready;
    d_raddr_ready = in_addr &&  sel_d && m_raddr_ready;
    m_rdata_ready = in_data && sel_rdata_ready;
    i_rdata_valid = in_data && !sel_d && m_rdata_valid;
    d_rdata_valid = in_data &&  sel_d && m_rdata_valid;
    i_rdata       = sel_d ? '0 : m_rdata;
    d_rdata       = sel_d ? m_rdata : '0;
  end

  // Writes come only from the data port and bypass the read FSM entirely.
  assign m_waddr_valid = d_waddr_valid;
  assign m_waddr       = d_waddr;
  assign d_waddr_ready = m_waddr_ready;
  assign m_wdata_valid = d_wdata_valid;
  assign m_wdata       = d_wdata;
  assign d_wdata_ready = m_wdata_ready;
  assign i_waddr_ready = 1'b0;
  assign i_wdata_ready = 1'b0;

  assign grant_d = gnt_q;

endmodule

// File: tb/tb_copperv_bus_arbiter.sv
// Directed bench for copperv_bus_arbiter: table of read transactions plus
// hand-written stall, reset-mid-read and write-during-read sequences.
module tb_copperv_bus_arbiter;

  localparam int W = 32;
`ifdef ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic i_raddr_valid, i_raddr_ready, i_rdata_valid, i_rdata_ready;
  logic [W-1:0] i_raddr, i_rdata;
  logic i_waddr_valid, i_waddr_ready, i_wdata_valid, i_wdata_ready;
  logic [W-1:0] i_waddr, i_wdata;
  logic d_raddr_valid, d_raddr_ready, d_rdata_valid, d_rdata_ready;
  logic [W-1:0] d_raddr, d_rdata;
  logic d_waddr_valid, d_waddr_ready, d_wdata_valid, d_wdata_ready;
  logic [W-1:0] d_waddr, d_wdata;
  logic m_raddr_valid, m_raddr_ready, m_rdata_valid, m_rdata_ready;
  logic [W-1:0] m_raddr, m_rdata;
  logic m_waddr_valid, m_waddr_ready, m_wdata_valid, m_wdata_ready;
  logic [W-1:0] m_waddr, m_wdata;
  logic grant_d;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  copperv_bus_arbiter #(.bus_width(W)) dut (
    .clk(clk), .rst(rst),
    .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
    .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
    .i_waddr_valid(i_waddr_valid), .i_waddr_ready(i_waddr_ready), .i_waddr(i_waddr),
    .i_wdata_valid(i_wdata_valid), .i_wdata_ready(i_wdata_ready), .i_wdata(i_wdata),
    .d_raddr_valid(d_raddr_valid), .d_raddr_ready(d_raddr_ready), .d_raddr(d_raddr),
    .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready), .d_rdata(d_rdata),
    .d_waddr_valid(d_waddr_valid), .d_waddr_ready(d_waddr_ready), .d_waddr(d_waddr),
    .d_wdata_valid(d_wdata_valid), .d_wdata_ready(d_wdata_ready), .d_wdata(d_wdata),
    .m_raddr_valid(m_raddr_valid), .m_raddr_ready(m_raddr_ready), .m_raddr(m_raddr),
    .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready), .m_rdata(m_rdata),
    .m_waddr_valid(m_waddr_valid), .m_waddr_ready(m_waddr_ready), .m_waddr(m_waddr),
    .m_wdata_valid(m_wdata_valid), .m_wdata_ready(m_wdata_ready), .m_wdata(m_wdata),
    .grant_d(grant_d)
  );

  typedef struct {
    logic         iv;
    logic [W-1:0] ia;
    logic         dv;
    logic [W-1:0] da;
    logic [W-1:0] data;
    logic         exp_d;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // One full read starting at a negedge in R_IDLE; returns at the negedge
  // after the data handshake (FSM back in R_IDLE).
  task automatic do_read(input logic iv, input logic [W-1:0] ia,
                         input logic dv, input logic [W-1:0] da,
                         input logic [W-1:0] data, input logic expd, input logic wr);
    i_raddr_valid = iv; i_raddr = ia;
    d_raddr_valid = dv; d_raddr = da;
    #1 chk("idle m_raddr_valid", m_raddr_valid, 0);
    @(negedge clk);
    m_raddr_ready = 1'b1;
    #1;
    chk("addr m_raddr_valid", m_raddr_valid, 1);
    chk("addr m_raddr", m_raddr, expd ? da : ia);
    chk("addr grant_d", grant_d, expd);
    chk("addr i_raddr_ready", i_raddr_ready, !expd);
    chk("addr d_raddr_ready", d_raddr_ready, expd);
    chk("addr rdata_valids", {i_rdata_valid, d_rdata_valid}, 0);
    @(negedge clk);
    i_raddr_valid = 1'b0; d_raddr_valid = 1'b0; m_raddr_ready = 1'b0;
    m_rdata_valid = 1'b1; m_rdata = data;
    i_rdata_ready = 1'b1; d_rdata_ready = 1'b1;
    if (wr) begin
      d_waddr_valid = 1'b1; d_waddr = 32'h8;
      d_wdata_valid = 1'b1; d_wdata = 32'h1234_5678;
      m_waddr_ready = 1'b1; m_wdata_ready = 1'b1;
    end
    #1;
    chk("data m_raddr_valid", m_raddr_valid, 0);
    chk("data granted valid", expd ? d_rdata_valid : i_rdata_valid, 1);
    chk("data other valid", expd ? i_rdata_valid : d_rdata_valid, 0);
    chk("data granted rdata", expd ? d_rdata : i_rdata, data);
    chk("data m_rdata_ready", m_rdata_ready, 1);
    chk("data grant_d", grant_d, expd);
    if (wr) begin
      chk("wr m_waddr_valid", m_waddr_valid, 1);
      chk("wr m_waddr", m_waddr, 32'h8);
      chk("wr m_wdata_valid", m_wdata_valid, 1);
      chk("wr m_wdata", m_wdata, 32'h1234_5678);
      chk("wr d_waddr_ready", d_waddr_ready, 1);
      chk("wr d_wdata_ready", d_wdata_ready, 1);
    end
    @(negedge clk);
    m_rdata_valid = 1'b0;
    d_waddr_valid = 1'b0; d_wdata_valid = 1'b0;
    m_waddr_ready = 1'b0; m_wdata_ready = 1'b0;
    #1;
    chk("back idle m_raddr_valid", m_raddr_valid, 0);
    chk("back idle rdata_valids", {i_rdata_valid, d_rdata_valid}, 0);
    chk("back idle m_rdata_ready", m_rdata_ready, 0);
  endtask

  initial begin
    // i-only, four contended rounds, then d-only and i-only
    tbl[0] = '{1'b1, 32'h100, 1'b0, 32'h0,  32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{1'b1, 32'h10,  1'b1, 32'h20, 32'hA0A0_0001, 1'b1};
    tbl[2] = '{1'b1, 32'h10,  1'b1, 32'h20, 32'hA0A0_0002, RR ? 1'b0 : 1'b1};
    tbl[3] = '{1'b1, 32'h10,  1'b1, 32'h20, 32'hA0A0_0003, 1'b1};
    tbl[4] = '{1'b1, 32'h10,  1'b1, 32'h20, 32'hA0A0_0004, RR ? 1'b0 : 1'b1};
    tbl[5] = '{1'b0, 32'h0,   1'b1, 32'h24, 32'hD000_0024, 1'b1};
    tbl[6] = '{1'b1, 32'h14,  1'b0, 32'h0,  32'h1000_0014, 1'b0};

    rst = 1'b1;
    i_raddr_valid = 0; i_raddr = '0; i_rdata_ready = 0;
    i_waddr_valid = 0; i_waddr = '0; i_wdata_valid = 0; i_wdata = '0;
    d_raddr_valid = 0; d_raddr = '0; d_rdata_ready = 0;
    d_waddr_valid = 0; d_waddr = '0; d_wdata_valid = 0; d_wdata = '0;
    m_raddr_ready = 0; m_rdata_valid = 0; m_rdata = '0;
    m_waddr_ready = 0; m_wdata_ready = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst m_raddr_valid", m_raddr_valid, 0);
    chk("rst raddr_readys", {i_raddr_ready, d_raddr_ready}, 0);
    chk("rst rdata_valids", {i_rdata_valid, d_rdata_valid}, 0);
    chk("rst m_rdata_ready", m_rdata_ready, 0);
    chk("rst grant_d", grant_d, 0);
    chk("rst i write readys", {i_waddr_ready, i_wdata_ready}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 7; k++)
      do_read(tbl[k].iv, tbl[k].ia, tbl[k].dv, tbl[k].da, tbl[k].data, tbl[k].exp_d, 1'b0);

    // Stalled read: memory withholds data while d keeps poking its request.
    i_raddr_valid = 1'b1; i_raddr = 32'h30; d_raddr = 32'h77;
    @(negedge clk);
    m_raddr_ready = 1'b1;
    #1 chk("stall addr handshake", m_raddr_valid, 1);
    @(negedge clk);
    i_raddr_valid = 1'b0; i_rdata_ready = 1'b1; m_rdata_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d_raddr_valid = (k % 2 == 0);
      #1;
      chk("stall grant_d", grant_d, 0);
      chk("stall m_raddr_valid", m_raddr_valid, 0);
      chk("stall m_raddr", m_raddr, 32'h30);
      chk("stall raddr_readys", {i_raddr_ready, d_raddr_ready}, 0);
      chk("stall rdata_valids", {i_rdata_valid, d_rdata_valid}, 0);
      @(negedge clk);
    end
    d_raddr_valid = 1'b0; m_raddr_ready = 1'b0;
    m_rdata_valid = 1'b1; m_rdata = 32'hCAFE_0030;
    #1;
    chk("stall i_rdata_valid", i_rdata_valid, 1);
    chk("stall i_rdata", i_rdata, 32'hCAFE_0030);
    @(negedge clk);
    m_rdata_valid = 1'b0;
    #1 chk("stall end idle", m_raddr_valid, 0);

    // Reset while a d read sits in R_DATA.
    @(negedge clk);
    d_raddr_valid = 1'b1; d_raddr = 32'h60;
    @(negedge clk);
    m_raddr_ready = 1'b1;
    #1 chk("rstmid grant_d before", grant_d, 1);
    @(negedge clk);
    d_raddr_valid = 1'b0; m_raddr_ready = 1'b0; d_rdata_ready = 1'b1;
    m_rdata_valid = 1'b1; rst = 1'b1;
    #1;
    chk("rstmid held d_rdata_valid", d_rdata_valid, 0);
    chk("rstmid held m_rdata_ready", m_rdata_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid grant_d after", grant_d, 0);
    chk("rstmid rdata_valids", {i_rdata_valid, d_rdata_valid}, 0);
    chk("rstmid m_rdata_ready", m_rdata_ready, 0);
    chk("rstmid m_raddr_valid", m_raddr_valid, 0);
    chk("rstmid raddr_readys", {i_raddr_ready, d_raddr_ready}, 0);
    m_rdata_valid = 1'b0;
    do_read(1'b1, 32'h4, 1'b0, 32'h0, 32'h0000_0404, 1'b0, 1'b0);

    // Data write issued while an instruction read is in R_DATA.
    do_read(1'b1, 32'h40, 1'b0, 32'h0, 32'h5555_AAAA, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
